// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU front-end types, widths and instruction field positions
package cpu_pkg;

    localparam int PC_W       = 8;
    localparam int INSTR_W    = 16;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2
    } fetch_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - program counter with load, modulo increment and hold
module program_counter #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_inc,
    input  logic [PC_W-1:0] i_target,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    // Load wins over increment; increment wraps naturally at 2^PC_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with registered instruction for decode
module fetch_unit #(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         mem_req,
    output logic [PC_W-1:0]              mem_addr,
    input  logic [cpu_pkg::INSTR_W-1:0]  mem_rdata,
    input  logic                         mem_ack,
    input  logic                         stall,
    input  logic                         pc_jump,
    input  logic                         pc_branch,
    input  logic [PC_W-1:0]              target_adr,
    output logic [cpu_pkg::INSTR_W-1:0]  instruction,
    output logic                         instr_valid,
    output logic [PC_W-1:0]              pc
);
    import cpu_pkg::*;

    fetch_state_e       r_state;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic               w_leave;
    logic               w_redirect;
    logic               w_inc;
    logic [PC_W-1:0]    w_pc;

    // Redirects only count on the cycle DECODE actually hands over to FETCH.
    assign w_leave    = (r_state == ST_DECODE) && !stall;
    assign w_redirect = w_leave && (pc_jump || pc_branch);
    assign w_inc      = w_leave && !(pc_jump || pc_branch);

    program_counter #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_redirect),
        .i_inc    (w_inc),
        .i_target (target_adr),
        .o_pc     (w_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        r_instr <= mem_rdata;
                        r_valid <= 1'b1;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (w_leave) begin
                        r_valid <= 1'b0;
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The request is a pure function of state, so a reset drops it on the next cycle.
    assign mem_req     = (r_state == ST_FETCH);
    assign mem_addr    = w_pc;
    assign pc          = w_pc;
    assign instruction = r_instr;
    assign instr_valid = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [7:0] RST_PC = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        stall = 1'b0;
    logic        pc_jump = 1'b0;
    logic        pc_branch = 1'b0;
    logic [7:0]  target_adr = '0;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [7:0]  pc;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase of the fetch/decode cycle plus architectural values.
    bit  m_waiting_ack;
    bit  m_presenting;
    bit  m_idle;
    int  m_pc;
    int  m_instr;

    fetch_unit #(.PC_W(8), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .stall       (stall),
        .pc_jump     (pc_jump),
        .pc_branch   (pc_branch),
        .target_adr  (target_adr),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_idle = 1; m_waiting_ack = 0; m_presenting = 0;
            m_pc = RST_PC; m_instr = 0;
        end else if (m_idle) begin
            m_idle = 0; m_waiting_ack = 1;
        end else if (m_waiting_ack) begin
            if (mem_ack) begin
                m_instr = mem_rdata;
                m_waiting_ack = 0; m_presenting = 1;
            end
        end else if (m_presenting && !stall) begin
            m_pc = (pc_jump || pc_branch) ? int'(target_adr) : (m_pc + 1) % 256;
            m_presenting = 0; m_waiting_ack = 1;
        end
    endtask

    task automatic step(input logic rst, input logic ack, input logic [15:0] rd,
                        input logic stl, input logic jmp, input logic br, input logic [7:0] tgt);
        rst_n = rst; mem_ack = ack; mem_rdata = rd;
        stall = stl; pc_jump = jmp; pc_branch = br; target_adr = tgt;
        @(posedge clk);
        model_edge();
        #1;
        check_eq("mem_req", mem_req, m_waiting_ack);
        check_eq("mem_addr", mem_addr, m_pc[7:0]);
        check_eq("pc", pc, m_pc[7:0]);
        check_eq("instr_valid", instr_valid, m_presenting);
        check_eq("instruction", instruction, m_instr[15:0]);
    endtask

    task automatic fetch_word(input int delay, input logic [15:0] rd);
        for (int i = 0; i < delay; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, rd, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic decode_go(input logic jmp, input logic br, input logic [7:0] tgt);
        step(1'b1, 1'b0, 16'h0, 1'b0, jmp, br, tgt);
    endtask

    initial begin
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 8'h33);
        check_eq("rst_pc", pc, RST_PC);
        check_eq("rst_valid", instr_valid, 1'b0);
        check_eq("rst_req", mem_req, 1'b0);
        check_eq("rst_instr", instruction, 16'h0000);

        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("seq_addr0", mem_addr, 8'h00);
        fetch_word(1, 16'h1000);
        check_eq("seq_valid0", instr_valid, 1'b1);
        decode_go(1'b0, 1'b0, 8'h00);
        check_eq("seq_addr1", mem_addr, 8'h01);
        check_eq("seq_valid_drop", instr_valid, 1'b0);
        fetch_word(1, 16'h1001);
        decode_go(1'b0, 1'b0, 8'h00);
        check_eq("seq_addr2", mem_addr, 8'h02);
        fetch_word(1, 16'h1002);

        decode_go(1'b1, 1'b0, 8'h40);
        check_eq("jump_addr", mem_addr, 8'h40);
        fetch_word(0, 16'h2222);
        decode_go(1'b0, 1'b1, 8'hFF);
        check_eq("branch_addr", mem_addr, 8'hFF);
        fetch_word(2, 16'h3333);
        decode_go(1'b0, 1'b0, 8'h00);
        check_eq("wrap_addr", mem_addr, 8'h00);

        fetch_word(1, 16'h5A5A);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, 1'b1, 8'h10);
            check_eq("stall_pc", pc, 8'h00);
            check_eq("stall_instr", instruction, 16'h5A5A);
            check_eq("stall_valid", instr_valid, 1'b1);
        end
        decode_go(1'b0, 1'b0, 8'h10);
        check_eq("post_stall_pc", pc, 8'h01);

        fetch_word(0, 16'h6666);
        decode_go(1'b1, 1'b1, 8'h77);
        check_eq("dual_redirect", mem_addr, 8'h77);
        fetch_word(0, 16'h7777);
        decode_go(1'b1, 1'b0, 8'h77);
        check_eq("self_loop", mem_addr, 8'h77);
        check_eq("self_loop_req", mem_req, 1'b1);
        fetch_word(0, 16'h7878);

        decode_go(1'b1, 1'b0, 8'h05);
        check_eq("pre_rst_addr", mem_addr, 8'h05);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("abort_req", mem_req, 1'b0);
        check_eq("abort_pc", pc, RST_PC);
        step(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("late_ack_instr", instruction, 16'h0000);
        check_eq("late_ack_valid", instr_valid, 1'b0);
        check_eq("refetch_addr", mem_addr, RST_PC);
        check_eq("refetch_req", mem_req, 1'b1);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b0, 8'h00);
            check_eq("wait_addr", mem_addr, RST_PC);
            check_eq("wait_req", mem_req, 1'b1);
        end
        step(1'b1, 1'b1, 16'h4A12, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("slow_instr", instruction, 16'h4A12);
        check_eq("slow_valid", instr_valid, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 64) != 0, ($urandom % 2) == 0, 16'($urandom),
                 ($urandom % 10) < 3, ($urandom % 7) == 0, ($urandom % 7) == 0, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
